// File: rtl/regfile_ctrl_pkg.sv
// regfile_ctrl_pkg
// Shared constants for the register-file micro-op sequencer:
//   - command opcodes carried on cmd_op
//   - register-file function codes driven on fun_sel
//   - register index encoding (0-3 = R1-R4, 4-7 = S1-S4)
//   - sequencer state enumeration
//   - command rejection rule shared by the FSM
package regfile_ctrl_pkg;

    // Command opcodes
    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_MOVE = 3'b010;
    localparam logic [2:0] OP_CLR  = 3'b011;
    localparam logic [2:0] OP_INC  = 3'b100;
    localparam logic [2:0] OP_DEC  = 3'b101;
    localparam logic [2:0] OP_SWAP = 3'b110;
    localparam logic [2:0] OP_RSVD = 3'b111;

    // Register-file function select codes
    localparam logic [2:0] FUN_DEC  = 3'b000;
    localparam logic [2:0] FUN_INC  = 3'b001;
    localparam logic [2:0] FUN_LOAD = 3'b010;
    localparam logic [2:0] FUN_CLR  = 3'b011;

    // Register indices
    localparam logic [2:0] IDX_R1 = 3'd0;
    localparam logic [2:0] IDX_R2 = 3'd1;
    localparam logic [2:0] IDX_R3 = 3'd2;
    localparam logic [2:0] IDX_R4 = 3'd3;
    localparam logic [2:0] IDX_S1 = 3'd4;
    localparam logic [2:0] IDX_S2 = 3'd5;
    localparam logic [2:0] IDX_S3 = 3'd6;
    localparam logic [2:0] IDX_S4 = 3'd7;

    // Sequencer states. ST_SW4 is only reached when S4 scrubbing is built in.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_EXEC = 3'd1,
        ST_SW1  = 3'd2,
        ST_SW2  = 3'd3,
        ST_SW3  = 3'd4,
        ST_SW4  = 3'd5,
        ST_ERR  = 3'd6
    } state_t;

    // A command is rejected when it uses the reserved opcode, or when a SWAP
    // names S4, which the SWAP sequence needs as its temporary.
    function automatic logic is_rejected(input logic [2:0] op,
                                         input logic [2:0] a,
                                         input logic [2:0] b);
        return (op == OP_RSVD) ||
               ((op == OP_SWAP) && ((a == IDX_S4) || (b == IDX_S4)));
    endfunction

endpackage

// File: rtl/regsel_decoder.sv
// regsel_decoder
// Combinational decode of one register index plus a write enable into the
// register file's active-low enable pair. Bit 3 of each field addresses the
// lowest-numbered register (R1 / S1). With wr_en low both fields are 1111.
// Ports:
//   idx     in  3  register index, 0-3 = R1-R4, 4-7 = S1-S4
//   wr_en   in  1  request a write this cycle
//   reg_sel out 4  active-low enables for R1..R4
//   scr_sel out 4  active-low enables for S1..S4
module regsel_decoder (
    input  logic [2:0] idx,
    input  logic       wr_en,
    output logic [3:0] reg_sel,
    output logic [3:0] scr_sel
);

    always_comb begin
        reg_sel = 4'b1111;
        scr_sel = 4'b1111;
        if (wr_en) begin
            // idx[2] picks the bank; idx[1:0] walks from bit 3 downwards.
            if (idx[2]) begin
                scr_sel = ~(4'b1000 >> idx[1:0]);
            end else begin
                reg_sel = ~(4'b1000 >> idx[1:0]);
            end
        end
    end

endmodule

// File: rtl/regfile_op_sequencer.sv
// regfile_op_sequencer
// Multi-cycle micro-op controller for an 8-entry register file (R1-R4,
// S1-S4). Accepts one command at a time and sequences LOAD, MOVE, CLR,
// INC-by-N, DEC-by-N and SWAP (S4 is the SWAP temporary).
//
// Handshake: a command is accepted on a rising edge where cmd_valid and
// cmd_ready are both high; cmd_ready is high only in IDLE. All command fields
// are captured on that edge and are ignored afterwards. cmd_ready stays low
// through the done/error cycle, so accepts are at least latency + 1 apart.
//
// Configuration macro: SWAP_SCRUB_EN -- when defined, SWAP adds a fourth
// cycle that clears S4 and done moves to that cycle.
//
// Ports:
//   clk        in  1      system clock, rising edge
//   rst_n      in  1      asynchronous active-low reset
//   cmd_valid  in  1      command present
//   cmd_ready  out 1      sequencer can accept a command (IDLE only)
//   cmd_op     in  3      opcode
//   cmd_dst    in  3      destination / SWAP operand a
//   cmd_src    in  3      source / SWAP operand b
//   cmd_count  in  CNT_W  INC/DEC repeat count
//   busy       out 1      command in progress
//   done       out 1      pulse in the last active cycle of a command
//   error      out 1      pulse in the cycle after a rejected command
//   out_a_sel  out 3      read-port A select
//   out_b_sel  out 3      read-port B select (unused by these ops, held 0)
//   fun_sel    out 3      register function code
//   reg_sel    out 4      active-low enables R1..R4 (bit3 = R1)
//   scr_sel    out 4      active-low enables S1..S4 (bit3 = S1)
//   i_mux_sel  out 1      0 = external data onto I, 1 = OutA onto I
//   fsm_state  out 3      current state encoding, for observation
module regfile_op_sequencer
    import regfile_ctrl_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [2:0]       cmd_dst,
    input  logic [2:0]       cmd_src,
    input  logic [CNT_W-1:0] cmd_count,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [2:0]       out_a_sel,
    output logic [2:0]       out_b_sel,
    output logic [2:0]       fun_sel,
    output logic [3:0]       reg_sel,
    output logic [3:0]       scr_sel,
    output logic             i_mux_sel,
    output logic [2:0]       fsm_state
);

    state_t           state;
    logic [2:0]       op_q;
    logic [2:0]       dst_q;
    logic [2:0]       src_q;
    logic [CNT_W-1:0] cnt_q;

    logic             wr_en;
    logic [2:0]       wr_idx;

    logic             is_rep;
    assign is_rep = (op_q == OP_INC) || (op_q == OP_DEC);

    // ------------------------------------------------------------------
    // State, captured command and repeat counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            op_q  <= OP_NOP;
            dst_q <= '0;
            src_q <= '0;
            cnt_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    cnt_q <= '0;
                    if (cmd_valid) begin
                        op_q  <= cmd_op;
                        dst_q <= cmd_dst;
                        src_q <= cmd_src;
                        cnt_q <= cmd_count;
                        if (is_rejected(cmd_op, cmd_dst, cmd_src)) begin
                            state <= ST_ERR;
                        end else if ((cmd_op == OP_SWAP) && (cmd_dst != cmd_src)) begin
                            state <= ST_SW1;
                        end else begin
                            // NOP, LOAD, MOVE, CLR, INC, DEC and SWAP a==a
                            state <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    // INC/DEC stay here while more than one write remains.
                    if (is_rep && (cnt_q > CNT_W'(1))) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        cnt_q <= '0;
                        state <= ST_IDLE;
                    end
                end
                ST_SW1: state <= ST_SW2;
                ST_SW2: state <= ST_SW3;
`ifdef SWAP_SCRUB_EN
                ST_SW3: state <= ST_SW4;
                ST_SW4: state <= ST_IDLE;
`else
                ST_SW3: state <= ST_IDLE;
`endif
                ST_ERR: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Control decode from registered state and captured command
    // ------------------------------------------------------------------
    always_comb begin
        cmd_ready = (state == ST_IDLE);
        busy      = (state != ST_IDLE);
        done      = 1'b0;
        error     = 1'b0;
        fun_sel   = FUN_DEC;
        out_a_sel = '0;
        i_mux_sel = 1'b0;
        wr_en     = 1'b0;
        wr_idx    = '0;
        case (state)
            ST_EXEC: begin
                done   = 1'b1;
                wr_idx = dst_q;
                case (op_q)
                    OP_LOAD: begin
                        fun_sel = FUN_LOAD;
                        wr_en   = 1'b1;
                    end
                    OP_MOVE: begin
                        out_a_sel = src_q;
                        i_mux_sel = 1'b1;
                        fun_sel   = FUN_LOAD;
                        wr_en     = 1'b1;
                    end
                    OP_CLR: begin
                        fun_sel = FUN_CLR;
                        wr_en   = 1'b1;
                    end
                    OP_INC, OP_DEC: begin
                        // A zero count is a single no-write cycle.
                        wr_en = (cnt_q != '0);
                        if (wr_en) begin
                            fun_sel = (op_q == OP_INC) ? FUN_INC : FUN_DEC;
                        end
                        done = (cnt_q <= CNT_W'(1));
                    end
                    default: begin
                        // NOP and SWAP with identical operands: no write.
                    end
                endcase
            end
            ST_SW1: begin
                // S4 <- a
                out_a_sel = dst_q;
                i_mux_sel = 1'b1;
                fun_sel   = FUN_LOAD;
                wr_en     = 1'b1;
                wr_idx    = IDX_S4;
            end
            ST_SW2: begin
                // a <- b
                out_a_sel = src_q;
                i_mux_sel = 1'b1;
                fun_sel   = FUN_LOAD;
                wr_en     = 1'b1;
                wr_idx    = dst_q;
            end
            ST_SW3: begin
                // b <- S4
                out_a_sel = IDX_S4;
                i_mux_sel = 1'b1;
                fun_sel   = FUN_LOAD;
                wr_en     = 1'b1;
                wr_idx    = src_q;
`ifdef SWAP_SCRUB_EN
                done      = 1'b0;
`else
                done      = 1'b1;
`endif
            end
            ST_SW4: begin
                // S4 <- 0
                fun_sel = FUN_CLR;
                wr_en   = 1'b1;
                wr_idx  = IDX_S4;
                done    = 1'b1;
            end
            ST_ERR: begin
                error = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign out_b_sel = 3'b000;
    assign fsm_state = state;

    regsel_decoder u_regsel_decoder (
        .idx     (wr_idx),
        .wr_en   (wr_en),
        .reg_sel (reg_sel),
        .scr_sel (scr_sel)
    );

endmodule

// File: tb/tb_regfile_op_sequencer.sv
// tb_regfile_op_sequencer
// Self-checking bench: a behavioural register file driven by the sequencer's
// control outputs, compared against a command-level reference model.
// Build with +define+SWAP_SCRUB_EN to exercise the S4-scrub variant.
module tb_regfile_op_sequencer;

    localparam int CNT_W = 4;
`ifdef SWAP_SCRUB_EN
    localparam bit SCRUB = 1'b1;
`else
    localparam bit SCRUB = 1'b0;
`endif
    localparam int SWAP_LAT = SCRUB ? 4 : 3;
    localparam logic [15:0] S4_AFTER_SWAP = SCRUB ? 16'h0000 : 16'h0001;

    localparam logic [2:0] NOP  = 3'd0;
    localparam logic [2:0] LOAD = 3'd1;
    localparam logic [2:0] MOVE = 3'd2;
    localparam logic [2:0] CLR  = 3'd3;
    localparam logic [2:0] INC  = 3'd4;
    localparam logic [2:0] DEC  = 3'd5;
    localparam logic [2:0] SWAP = 3'd6;
    localparam logic [2:0] RSVD = 3'd7;

    // ---------------- clock / reset / DUT ----------------
    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [2:0]       cmd_op = '0;
    logic [2:0]       cmd_dst = '0;
    logic [2:0]       cmd_src = '0;
    logic [CNT_W-1:0] cmd_count = '0;
    logic             busy, done, error;
    logic [2:0]       out_a_sel, out_b_sel, fun_sel;
    logic [3:0]       reg_sel, scr_sel;
    logic             i_mux_sel;
    logic [2:0]       fsm_state;
    logic [15:0]      ext_data = '0;

    always #5 clk = ~clk;

    regfile_op_sequencer #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_dst   (cmd_dst),
        .cmd_src   (cmd_src),
        .cmd_count (cmd_count),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .out_a_sel (out_a_sel),
        .out_b_sel (out_b_sel),
        .fun_sel   (fun_sel),
        .reg_sel   (reg_sel),
        .scr_sel   (scr_sel),
        .i_mux_sel (i_mux_sel),
        .fsm_state (fsm_state)
    );

    // ---------------- register file driven by the DUT ----------------
    logic [15:0] rf [8] = '{default: 16'h0000};
    int          cyc = 0;
    int          accept_cyc[$];

    always @(posedge clk) begin : rf_model
        int widx;
        widx = -1;
        for (int i = 0; i < 4; i++) begin
            if (!reg_sel[3-i]) widx = i;
            if (!scr_sel[3-i]) widx = 4 + i;
        end
        cyc <= cyc + 1;
        if (cmd_valid && cmd_ready) accept_cyc.push_back(cyc);
        if (widx >= 0) begin
            case (fun_sel)
                3'b000:  rf[widx] <= rf[widx] - 16'd1;
                3'b001:  rf[widx] <= rf[widx] + 16'd1;
                3'b010:  rf[widx] <= i_mux_sel ? rf[out_a_sel] : ext_data;
                3'b011:  rf[widx] <= 16'h0000;
                default: ;
            endcase
        end
    end

    // ---------------- reference model and scoreboard ----------------
    logic [15:0] exp_rf [8] = '{default: 16'h0000};
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all_regs(input string name);
        logic [127:0] a, e;
        for (int i = 0; i < 8; i++) begin
            a[i*16 +: 16] = rf[i];
            e[i*16 +: 16] = exp_rf[i];
        end
        check(name, a, e);
    endtask

    // Command-level effect of one command; returns latency, write count and
    // whether it ends with done or error.
    task automatic apply_ref(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b,
                             input logic [3:0] cnt, input logic [15:0] data,
                             output int lat, output int writes, output bit e_done, output bit e_err);
        logic [15:0] t;
        lat = 1; writes = 0; e_done = 1'b1; e_err = 1'b0;
        if (op == RSVD || (op == SWAP && (a == 3'd7 || b == 3'd7))) begin
            e_done = 1'b0; e_err = 1'b1;
        end else begin
            case (op)
                LOAD: begin exp_rf[a] = data; writes = 1; end
                MOVE: begin exp_rf[a] = exp_rf[b]; writes = 1; end
                CLR:  begin exp_rf[a] = 16'h0000; writes = 1; end
                INC:  begin exp_rf[a] = exp_rf[a] + 16'(cnt); writes = int'(cnt); lat = (cnt == 0) ? 1 : int'(cnt); end
                DEC:  begin exp_rf[a] = exp_rf[a] - 16'(cnt); writes = int'(cnt); lat = (cnt == 0) ? 1 : int'(cnt); end
                SWAP: begin
                    if (a != b) begin
                        t = exp_rf[a];
                        exp_rf[a] = exp_rf[b];
                        exp_rf[b] = t;
                        exp_rf[7] = SCRUB ? 16'h0000 : t;
                        lat = SWAP_LAT;
                        writes = SWAP_LAT;
                    end
                end
                default: ;
            endcase
        end
    endtask

    // ---------------- driver ----------------
    task automatic run_cmd(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b,
                           input logic [3:0] cnt, input logic [15:0] data,
                           output int lat, output int writes, output bit got_done, output bit got_err);
        int waited;
        lat = 0; writes = 0; got_done = 1'b0; got_err = 1'b0;
        @(negedge clk);
        waited = 0;
        while (!cmd_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("ready_before_cmd", cmd_ready, 1'b1);
        check("idle_outputs", {reg_sel, scr_sel, fun_sel, out_a_sel, out_b_sel, i_mux_sel, busy, done, error},
              {8'hFF, 3'b000, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0});
        cmd_op = op; cmd_dst = a; cmd_src = b; cmd_count = cnt; ext_data = data;
        cmd_valid = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) begin
                // Fields are captured on accept; scramble them to prove it.
                cmd_valid = 1'b0;
                cmd_op = 3'($urandom); cmd_dst = 3'($urandom);
                cmd_src = 3'($urandom); cmd_count = 4'($urandom);
            end
            check("busy_in_cmd", {busy, cmd_ready}, 2'b10);
            check("enables_onehot", $countones(~{reg_sel, scr_sel}) <= 1, 1'b1);
            if ((~{reg_sel, scr_sel}) != 8'h00) writes++;
            if (done) got_done = 1'b1;
            if (error) got_err = 1'b1;
            if (done || error) begin
                lat = c;
                break;
            end
        end
        if (lat == 0) check("cmd_timeout", 1'b0, 1'b1);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic [2:0]  op;
        logic [2:0]  a;
        logic [2:0]  b;
        logic [3:0]  cnt;
        logic [15:0] data;
        int          lat;
        int          writes;
        bit          e_done;
        bit          e_err;
        int          chk_idx;
        logic [15:0] chk_val;
    } vec_t;

    vec_t vec[13];

    initial begin
        int lat, writes, m_lat, m_writes, n0, gap, waited;
        bit got_done, got_err, m_done, m_err;
        logic [2:0] r_op, r_a, r_b;
        logic [3:0] r_cnt;
        logic [15:0] r_data;

        vec[0]  = '{LOAD, 3'd1, 3'd0, 4'd0, 16'hA5A5, 1, 1, 1'b1, 1'b0, 1, 16'hA5A5};
        vec[1]  = '{LOAD, 3'd0, 3'd0, 4'd0, 16'h0001, 1, 1, 1'b1, 1'b0, 0, 16'h0001};
        vec[2]  = '{LOAD, 3'd2, 3'd0, 4'd0, 16'h00F0, 1, 1, 1'b1, 1'b0, 2, 16'h00F0};
        vec[3]  = '{MOVE, 3'd4, 3'd1, 4'd0, 16'h1234, 1, 1, 1'b1, 1'b0, 4, 16'hA5A5};
        vec[4]  = '{SWAP, 3'd0, 3'd2, 4'd0, 16'h0000, SWAP_LAT, SWAP_LAT, 1'b1, 1'b0, 0, 16'h00F0};
        vec[5]  = '{NOP,  3'd0, 3'd0, 4'd0, 16'h0000, 1, 0, 1'b1, 1'b0, 2, 16'h0001};
        vec[6]  = '{NOP,  3'd3, 3'd5, 4'd7, 16'h0000, 1, 0, 1'b1, 1'b0, 7, S4_AFTER_SWAP};
        vec[7]  = '{LOAD, 3'd3, 3'd0, 4'd0, 16'hFFFE, 1, 1, 1'b1, 1'b0, 3, 16'hFFFE};
        vec[8]  = '{INC,  3'd3, 3'd0, 4'd3, 16'h0000, 3, 3, 1'b1, 1'b0, 3, 16'h0001};
        vec[9]  = '{INC,  3'd3, 3'd0, 4'd0, 16'h0000, 1, 0, 1'b1, 1'b0, 3, 16'h0001};
        vec[10] = '{SWAP, 3'd1, 3'd7, 4'd0, 16'h0000, 1, 0, 1'b0, 1'b1, 1, 16'hA5A5};
        vec[11] = '{RSVD, 3'd2, 3'd3, 4'd0, 16'hBEEF, 1, 0, 1'b0, 1'b1, 7, S4_AFTER_SWAP};
        vec[12] = '{SWAP, 3'd1, 3'd1, 4'd0, 16'h0000, 1, 0, 1'b1, 1'b0, 1, 16'hA5A5};

        // ---- reset ----
        repeat (3) @(negedge clk);
        check("reset_outputs", {reg_sel, scr_sel, fun_sel, out_a_sel, out_b_sel, i_mux_sel, busy, done, error, cmd_ready},
              {8'hFF, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_idle", {reg_sel, scr_sel, busy, cmd_ready}, {8'hFF, 1'b0, 1'b1});

        // ---- table-driven vectors ----
        for (int i = 0; i < 13; i++) begin
            run_cmd(vec[i].op, vec[i].a, vec[i].b, vec[i].cnt, vec[i].data, lat, writes, got_done, got_err);
            apply_ref(vec[i].op, vec[i].a, vec[i].b, vec[i].cnt, vec[i].data, m_lat, m_writes, m_done, m_err);
            check($sformatf("vec%0d_latency", i), lat, vec[i].lat);
            check($sformatf("vec%0d_writes", i), writes, vec[i].writes);
            check($sformatf("vec%0d_done_err", i), {got_done, got_err}, {vec[i].e_done, vec[i].e_err});
            @(posedge clk); #1;
            check($sformatf("vec%0d_ready_after", i), {cmd_ready, busy}, 2'b10);
            check($sformatf("vec%0d_reg", i), rf[vec[i].chk_idx], vec[i].chk_val);
            check_all_regs($sformatf("vec%0d_all_regs", i));
        end

        // ---- back-to-back CLR R1, DEC R1 by 2 with cmd_valid held ----
        @(negedge clk);
        waited = 0;
        while (!cmd_ready && waited < 20) begin @(negedge clk); waited++; end
        n0 = accept_cyc.size();
        cmd_op = CLR; cmd_dst = 3'd0; cmd_src = 3'd0; cmd_count = 4'd0;
        cmd_valid = 1'b1;
        @(negedge clk);
        check("b2b_clr_done", {done, cmd_ready}, 2'b10);
        cmd_op = DEC; cmd_count = 4'd2;
        @(negedge clk);
        check("b2b_ready_gap", {cmd_ready, busy}, 2'b10);
        @(negedge clk);
        cmd_valid = 1'b0;
        check("b2b_dec_first", {busy, done, reg_sel}, {1'b1, 1'b0, 4'b0111});
        @(negedge clk);
        check("b2b_dec_done", {done, reg_sel}, {1'b1, 4'b0111});
        gap = (accept_cyc.size() >= n0 + 2) ? accept_cyc[n0+1] - accept_cyc[n0] : -1;
        check("b2b_accept_spacing", gap, 2);
        apply_ref(CLR, 3'd0, 3'd0, 4'd0, 16'h0, m_lat, m_writes, m_done, m_err);
        apply_ref(DEC, 3'd0, 3'd0, 4'd2, 16'h0, m_lat, m_writes, m_done, m_err);
        @(posedge clk); #1;
        check("b2b_r1", rf[0], 16'hFFFE);
        check_all_regs("b2b_all_regs");

        // ---- reset asserted during SW2 ----
        @(negedge clk);
        cmd_op = SWAP; cmd_dst = 3'd0; cmd_src = 3'd2; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("sw1_enables", {reg_sel, scr_sel, i_mux_sel, out_a_sel}, {4'b1111, 4'b1110, 1'b1, 3'd0});
        @(negedge clk);
        check("sw2_enables", {reg_sel, scr_sel, out_a_sel}, {4'b0111, 4'b1111, 3'd2});
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_enables", {reg_sel, scr_sel, busy, done}, {8'hFF, 1'b0, 1'b0});
        @(negedge clk);
        check("rst_mid_no_done", {done, busy, reg_sel, scr_sel}, {1'b0, 1'b0, 8'hFF});
        rst_n = 1'b1;
        exp_rf[7] = exp_rf[0];  // only SW1 completed
        @(posedge clk); #1;
        check_all_regs("rst_mid_regs");
        run_cmd(LOAD, 3'd2, 3'd0, 4'd0, 16'h5A5A, lat, writes, got_done, got_err);
        apply_ref(LOAD, 3'd2, 3'd0, 4'd0, 16'h5A5A, m_lat, m_writes, m_done, m_err);
        check("post_rst_load", {lat, writes, got_done, got_err}, {m_lat, m_writes, m_done, m_err});
        @(posedge clk); #1;
        check_all_regs("post_rst_regs");

        // ---- randomized commands against the reference model ----
        for (int n = 0; n < 150; n++) begin
            r_op = 3'($urandom_range(0, 7));
            r_a = 3'($urandom_range(0, 7));
            r_b = 3'($urandom_range(0, 7));
            r_cnt = 4'($urandom_range(0, 6));
            r_data = 16'($urandom);
            run_cmd(r_op, r_a, r_b, r_cnt, r_data, lat, writes, got_done, got_err);
            apply_ref(r_op, r_a, r_b, r_cnt, r_data, m_lat, m_writes, m_done, m_err);
            check($sformatf("rand%0d_op%0d_timing", n, r_op), {lat, writes, got_done, got_err},
                  {m_lat, m_writes, m_done, m_err});
            @(posedge clk); #1;
            check($sformatf("rand%0d_regs", n), {cmd_ready}, 1'b1);
            check_all_regs($sformatf("rand%0d_all_regs", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_op_sequencer.md
Name: regfile_op_sequencer

Overview:
- Multi-cycle micro-op controller for the 8-entry register file: R1–R4 plus scratch registers S1–S4.
- Accepts one command at a time over a valid/ready handshake.
- Drives the file's OutASel/OutBSel/FunSel/RegSel/ScrSel, plus IMuxSel for the external mux feeding the file's I input (0 = external data, 1 = file OutA loopback).
- Sequences LOAD, MOVE, CLR, INC-by-N, DEC-by-N and SWAP; SWAP uses S4 as temporary.

Parameters:
- CNT_W, 4, width of the CmdCount repeat field for INC/DEC.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- CmdValid  in  1  command present.
- CmdReady  out  1  sequencer can accept a command; high only in IDLE.
- CmdOp  in  3  opcode: 000 NOP, 001 LOAD, 010 MOVE, 011 CLR, 100 INC, 101 DEC, 110 SWAP, 111 reserved.
- CmdDst  in  3  destination / SWAP operand A; 0–3 = R1–R4, 4–7 = S1–S4.
- CmdSrc  in  3  source / SWAP operand B; same encoding.
- CmdCount  in  CNT_W  repeat count for INC/DEC.
- Busy  out  1  command in progress.
- Done  out  1  one-cycle pulse during the last active cycle of a command.
- Error  out  1  one-cycle pulse when a command is rejected.
- OutASel  out  3  register file read-port A select.
- OutBSel  out  3  register file read-port B select.
- FunSel  out  3  register function: 000 Q-1, 001 Q+1, 010 load I, 011 clear.
- RegSel  out  4  active-low enables for R1..R4; bit3 = R1.
- ScrSel  out  4  active-low enables for S1..S4; bit3 = S1.
- IMuxSel  out  1  0 = external data onto I, 1 = OutA onto I.

Behaviour:
- Reset (asynchronous, active-low), and every IDLE cycle:
  - RegSel = ScrSel = 4'b1111, so no register is written.
  - FunSel = 000, OutASel = OutBSel = 000, IMuxSel = 0.
  - Busy = Done = Error = 0.
  - Repeat counter cleared; state = IDLE.
- Reset asserted mid-command: enables drop to 1111 immediately; the command is abandoned; no Done.
- Handshake:
  - A command is accepted on a rising edge where CmdValid & CmdReady.
  - Command fields are captured into internal registers; inputs are don't-care afterwards.
  - Control outputs decode from the registered state and captured command.
  - A write happens on the edge that ends a cycle in which an enable is low.
- Exactly one enable bit is low in any write cycle; RegSel and ScrSel are never both active.
- States and transitions:
  - IDLE → EXEC on accept of NOP/LOAD/MOVE/CLR/INC/DEC.
  - IDLE → SW1 on accept of a valid SWAP.
  - Reserved opcode or illegal SWAP: Error pulses in the cycle after the accept edge; no writes; back to IDLE.
- EXEC, per opcode:
  - NOP: one cycle, no write, Done.
  - LOAD: FunSel 010, IMuxSel 0, dst enable low; 1 cycle.
  - MOVE: OutASel = src, IMuxSel 1, FunSel 010, dst enable low; 1 cycle.
  - CLR: FunSel 011, dst enable low; 1 cycle.
  - INC/DEC: FunSel 001/000, dst enable low for exactly CmdCount consecutive cycles; Done in the last of them.
  - INC/DEC with CmdCount = 0: one cycle, no write, Done.
- MOVE with src == dst: performed normally (writes same value).
- SWAP a(dst), b(src):
  - SW1: S4 ← a (OutASel = a, IMuxSel 1, FunSel 010, ScrSel 1110).
  - SW2: a ← b.
  - SW3: b ← S4, Done.
  - Total 3 cycles.
- SWAP special cases:
  - a == b: single cycle, no write, Done.
  - Either operand == S4 (111): Error, no writes.
- Busy = 1 in every non-IDLE state.
- Minimum spacing between accepts is latency + 1 cycle, because CmdReady is low in the Done cycle.
- Width rules: the INC/DEC counter is CNT_W bits, counting down from CmdCount; wrap of register contents is the register's own behaviour.

Optional Feature:
- Macro: SWAP_SCRUB_EN.
- Defined: SWAP adds a fourth state SW4 that clears S4 (FunSel 011, ScrSel 1110).
  - Done moves to SW4; SWAP latency becomes 4.
  - Error and a == b cases are unchanged.
- Undefined: S4 retains operand A's old value after SWAP; latency 3.

Decomposition:
- Package regfile_ctrl_pkg holds:
  - opcode constants;
  - FunSel codes (DEC, INC, LOAD, CLR);
  - register index constants R1..S4;
  - the state enum.
- Sub-module regsel_decoder: combinational; maps a 3-bit index plus write-enable to the active-low {RegSel, ScrSel} pair. Instantiated once on the write index.

Test Plan:
- Reset, then LOAD to R2 with external 16'hA5A5 → 1 cycle, Done; R2 = A5A5; all other registers unchanged; enables 1111 before and after.
- MOVE R2→S1, then SWAP R1 (=0001) with R3 (=00F0) → R1 = 00F0, R3 = 0001, S4 = 0001; Done in cycle 3 after the accept edge; with SWAP_SCRUB_EN, S4 = 0000 and Done in cycle 4.
- INC R4 (=FFFE) Count = 3 → 3 write cycles; R4 = 0001 (wrap); Done on the third cycle; INC with Count = 0 → Done after 1 cycle, R4 unchanged.
- SWAP with operand S4, and reserved op 111 → Error pulse, no enable low, CmdReady back high the next cycle; SWAP R2,R2 → Done, no write.
- CmdValid held high for back-to-back CLR R1 then DEC R1 Count = 2 → accepts exactly 2 cycles apart; R1 = FFFE.
- Reset asserted during SW2 → RegSel/ScrSel = 1111 within the same cycle; Busy = 0; no Done; next command accepted normally after Reset deasserts.
